// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types (word_t, memstate_t) and the link-compare byte-offset width OFF_W
package cpu_types_pkg;
  localparam int OFF_W = 2;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, REQ, HOLD} memstate_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: dcache request/response bundle
//   master (MEM stage): drives dmemREN/dmemWEN/dmemaddr/dmemstore, receives dhit/dmemload
//   slave  (dcache)   : the mirror image
interface mem_access_unit_if #(parameter int DATA_W = 32);
  logic dmemREN, dmemWEN, dhit;
  logic [DATA_W-1:0] dmemaddr, dmemstore, dmemload;
  modport master (output dmemREN, dmemWEN, dmemaddr, dmemstore, input dhit, dmemload);
  modport slave (input dmemREN, dmemWEN, dmemaddr, dmemstore, output dhit, dmemload);
endinterface

// File: rtl/mem_access_unit_llsc_link.sv
// llsc_link: per-core LL/SC link register with word-address compare and snoop-invalidate clear
//   ll_set     : LL completed this cycle, latch addr word and set valid (wins over snoop)
//   sc_clear   : SC decided this cycle, drop the link
//   addr       : current EX/MEM address; sc_ok is the SC success verdict for it
//   ccinv/snoop_addr : coherence invalidate; a matching word clears the link and fails a same-cycle SC
module llsc_link #(
  parameter int DATA_W = 32,
  parameter int OFF_W = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ll_set,
  input  logic              sc_clear,
  input  logic [DATA_W-1:0] addr,
  input  logic              ccinv,
  input  logic [DATA_W-1:0] snoop_addr,
  output logic              sc_ok
);
  logic link_valid_q, link_valid_d;
  logic [DATA_W-OFF_W-1:0] link_addr_q, link_addr_d;
  logic snoop_hit;
  logic unused_lsb;
  assign unused_lsb = ^{addr[OFF_W-1:0], snoop_addr[OFF_W-1:0]};
  assign snoop_hit = ccinv & (snoop_addr[DATA_W-1:OFF_W] == link_addr_q);
  assign sc_ok = link_valid_q & (addr[DATA_W-1:OFF_W] == link_addr_q) & ~snoop_hit;
  always_comb begin
    link_valid_d = ll_set | (link_valid_q & ~sc_clear & ~snoop_hit);
    link_addr_d = ll_set ? addr[DATA_W-1:OFF_W] : link_addr_q;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q <= link_addr_d;
    end
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage dcache access engine feeding the MEM/WB latch
//   Inputs : CLK, nRST (async, active-low), EX/MEM operands (exm_*), ccinv/ccsnoopaddr snoop, wb_ready
//   dc     : dcache handshake (master side of mem_access_unit_if)
//   Outputs: mem_dload, memwb_enable, mem_stall, halt_out
//   Build option: define MEM_LLSC_EN for the LL/SC link register; otherwise LL is a plain load and
//   SC a plain store that always reports 1.
module mem_access_unit
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W = cpu_types_pkg::OFF_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              exm_valid,
  input  logic              exm_ren,
  input  logic              exm_wen,
  input  logic              exm_ll,
  input  logic              exm_sc,
  input  logic              exm_halt,
  input  logic [DATA_W-1:0] exm_addr,
  input  logic [DATA_W-1:0] exm_wdata,
  input  logic              ccinv,
  input  logic [DATA_W-1:0] ccsnoopaddr,
  input  logic              wb_ready,
  mem_access_unit_if.master dc,
  output logic [DATA_W-1:0] mem_dload,
  output logic              memwb_enable,
  output logic              mem_stall,
  output logic              halt_out
);
  memstate_t state_q, state_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d, rd_val, dload;
  logic halt_q, halt_d, halt_now, halt_act;
  logic is_ld, is_st, is_sc, mem_op, mem_go, acc, sc_ok;
  logic ren, wen, en, stall;
  assign halt_now = exm_valid & exm_halt;
  assign halt_act = halt_q | halt_now;
  assign halt_d = halt_act;
  assign is_st = exm_wen;
  assign is_ld = exm_ren & ~exm_wen;
  assign is_sc = exm_sc & exm_wen;
  assign mem_op = exm_valid & (exm_ren | exm_wen) & ~halt_act;
  // a failed SC never reaches the cache and retires like an ALU op
  assign mem_go = mem_op & (~is_sc | sc_ok);
  assign acc = (state_q == IDLE && mem_go) || state_q == REQ;
  assign rd_val = is_sc ? {{(DATA_W-1){1'b0}}, 1'b1} : dc.dmemload;
`ifdef MEM_LLSC_EN
  llsc_link #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_link (
    .CLK       (CLK),
    .nRST      (nRST),
    .ll_set    (acc & dc.dhit & is_ld & exm_ll),
    .sc_clear  (state_q == IDLE && mem_op && is_sc),
    .addr      (exm_addr),
    .ccinv     (ccinv),
    .snoop_addr(ccsnoopaddr),
    .sc_ok     (sc_ok)
  );
`else
  logic unused_llsc;
  assign unused_llsc = ^{exm_ll, ccinv, ccsnoopaddr};
  assign sc_ok = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    buf_data_d = buf_data_q;
    ren = 1'b0;
    wen = 1'b0;
    en = 1'b0;
    stall = 1'b0;
    dload = '0;
    if (state_q == HOLD) begin
      dload = buf_data_q;
      en = wb_ready;
      stall = ~wb_ready;
      state_d = wb_ready ? IDLE : HOLD;
    end else if (acc) begin
      ren = is_ld;
      wen = is_st;
      stall = 1'b1;
      state_d = REQ;
      if (dc.dhit) begin
        // the hit value bypasses the buffer when WB can take it this cycle
        buf_data_d = (is_ld | is_sc) ? rd_val : buf_data_q;
        en = wb_ready;
        stall = ~wb_ready;
        dload = wb_ready ? rd_val : '0;
        state_d = wb_ready ? IDLE : HOLD;
      end
    end else if (exm_valid) begin
      en = wb_ready;
      stall = ~wb_ready;
    end
  end
  // outputs are forced low for the whole time reset is held, not just after the edge
  assign dc.dmemREN = nRST & ren;
  assign dc.dmemWEN = nRST & wen;
  assign dc.dmemaddr = (nRST & (ren | wen)) ? exm_addr : '0;
  assign dc.dmemstore = (nRST & wen) ? exm_wdata : '0;
  assign mem_dload = nRST ? dload : '0;
  assign memwb_enable = nRST & en;
  assign mem_stall = nRST & stall;
  assign halt_out = nRST & halt_act;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      buf_data_q <= '0;
      halt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_data_q <= buf_data_d;
      halt_q <= halt_d;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven single-cycle vectors plus hand-written multi-cycle sequences
module tb_mem_access_unit;
`ifdef MEM_LLSC_EN
  localparam logic LLSC = 1'b1;
`else
  localparam logic LLSC = 1'b0;
`endif
  logic CLK = 1'b0, nRST = 1'b0;
  logic exm_valid, exm_ren, exm_wen, exm_ll, exm_sc, exm_halt, ccinv, wb_ready;
  logic [31:0] exm_addr, exm_wdata, ccsnoopaddr, mem_dload;
  logic memwb_enable, mem_stall, halt_out;
  int checks = 0, errors = 0;
  mem_access_unit_if #(.DATA_W(32)) dc ();
  mem_access_unit dut (
    .CLK(CLK), .nRST(nRST), .exm_valid(exm_valid), .exm_ren(exm_ren), .exm_wen(exm_wen),
    .exm_ll(exm_ll), .exm_sc(exm_sc), .exm_halt(exm_halt), .exm_addr(exm_addr),
    .exm_wdata(exm_wdata), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .wb_ready(wb_ready),
    .dc(dc.master), .mem_dload(mem_dload), .memwb_enable(memwb_enable), .mem_stall(mem_stall),
    .halt_out(halt_out)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic v, r, w, hit, wb;
    logic [31:0] addr, wdata, load;
    logic e_ren, e_wen, e_en, e_stall;
    logic [31:0] e_dload, e_addr, e_store;
  } vec_t;
  vec_t vt[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, r, w, ll, sc, hl, hit, wb,
                       input logic [31:0] a, wd, ld);
    exm_valid = v; exm_ren = r; exm_wen = w; exm_ll = ll; exm_sc = sc; exm_halt = hl;
    dc.dhit = hit; wb_ready = wb; exm_addr = a; exm_wdata = wd; dc.dmemload = ld;
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    ccinv = 1'b0; ccsnoopaddr = '0;
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0,
              1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h0, 32'h0,
              1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0};
    vt[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0,
              1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 32'hCAFE_F00D,
              1'b1, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h10, 32'h0};
    vt[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 32'h1234, 32'h0,
              1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h80, 32'h1234};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hC4, 32'h5678, 32'h0,
              1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hC4, 32'h5678};
    drive(1, 1, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0);
    #3;
    chk("rst_ren", dc.dmemREN, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_en", memwb_enable, 0);
    chk("rst_addr", dc.dmemaddr, 0);
    chk("rst_halt", halt_out, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    #10 nRST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      drive(vt[i].v, vt[i].r, vt[i].w, 0, 0, 0, vt[i].hit, vt[i].wb, vt[i].addr, vt[i].wdata, vt[i].load);
      @(negedge CLK);
      chk($sformatf("v%0d_ren", i), dc.dmemREN, vt[i].e_ren);
      chk($sformatf("v%0d_wen", i), dc.dmemWEN, vt[i].e_wen);
      chk($sformatf("v%0d_en", i), memwb_enable, vt[i].e_en);
      chk($sformatf("v%0d_stall", i), mem_stall, vt[i].e_stall);
      chk($sformatf("v%0d_dload", i), mem_dload, vt[i].e_dload);
      chk($sformatf("v%0d_addr", i), dc.dmemaddr, vt[i].e_addr);
      chk($sformatf("v%0d_store", i), dc.dmemstore, vt[i].e_store);
    end
    tick();
    drive(1, 1, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0);
    @(negedge CLK);
    chk("ldA_c1_ren", dc.dmemREN, 1); chk("ldA_c1_stall", mem_stall, 1); chk("ldA_c1_en", memwb_enable, 0);
    tick();
    @(negedge CLK);
    chk("ldA_c2_ren", dc.dmemREN, 1); chk("ldA_c2_stall", mem_stall, 1); chk("ldA_c2_addr", dc.dmemaddr, 32'h40);
    tick();
    dc.dhit = 1; dc.dmemload = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk("ldA_c3_ren", dc.dmemREN, 1); chk("ldA_c3_stall", mem_stall, 0);
    chk("ldA_c3_en", memwb_enable, 1); chk("ldA_c3_dload", mem_dload, 32'hDEAD_BEEF);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge CLK);
    chk("ldA_after_ren", dc.dmemREN, 0); chk("ldA_after_en", memwb_enable, 0);
    tick();
    drive(1, 1, 0, 0, 0, 0, 1, 0, 32'h50, 0, 32'h55);
    @(negedge CLK);
    chk("ldB_c1_ren", dc.dmemREN, 1); chk("ldB_c1_stall", mem_stall, 1); chk("ldB_c1_en", memwb_enable, 0);
    tick();
    dc.dhit = 0; dc.dmemload = 32'h99;
    @(negedge CLK);
    chk("ldB_c2_ren", dc.dmemREN, 0); chk("ldB_c2_dload", mem_dload, 32'h55);
    chk("ldB_c2_stall", mem_stall, 1); chk("ldB_c2_en", memwb_enable, 0);
    tick();
    wb_ready = 1;
    @(negedge CLK);
    chk("ldB_c3_ren", dc.dmemREN, 0); chk("ldB_c3_en", memwb_enable, 1);
    chk("ldB_c3_dload", mem_dload, 32'h55); chk("ldB_c3_stall", mem_stall, 0);
    tick();
    drive(1, 1, 0, 1, 0, 0, 1, 1, 32'h100, 0, 32'h7);
    @(negedge CLK);
    chk("ll_en", memwb_enable, 1);
    tick();
    drive(1, 0, 1, 0, 1, 0, 1, 1, 32'h100, 32'hAA, 0);
    @(negedge CLK);
    chk("sc1_wen", dc.dmemWEN, 1); chk("sc1_dload", mem_dload, 1); chk("sc1_en", memwb_enable, 1);
    tick();
    @(negedge CLK);
    chk("sc2_wen", dc.dmemWEN, !LLSC); chk("sc2_dload", mem_dload, {31'b0, !LLSC});
    chk("sc2_en", memwb_enable, 1); chk("sc2_stall", mem_stall, 0);
    tick();
    drive(1, 1, 0, 1, 0, 0, 1, 1, 32'h100, 0, 32'h7);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    ccinv = 1; ccsnoopaddr = 32'h102;
    tick();
    ccinv = 0;
    drive(1, 0, 1, 0, 1, 0, 1, 1, 32'h100, 32'hBB, 0);
    @(negedge CLK);
    chk("scinv_wen", dc.dmemWEN, !LLSC); chk("scinv_dload", mem_dload, {31'b0, !LLSC});
    tick();
    drive(1, 1, 0, 1, 0, 0, 1, 1, 32'h100, 0, 32'h7);
    tick();
    drive(1, 0, 1, 0, 1, 0, 1, 1, 32'h100, 32'hCC, 0);
    ccinv = 1; ccsnoopaddr = 32'h101;
    @(negedge CLK);
    chk("scsame_wen", dc.dmemWEN, !LLSC); chk("scsame_dload", mem_dload, {31'b0, !LLSC});
    tick();
    ccinv = 0;
    drive(1, 1, 0, 1, 0, 0, 1, 1, 32'h100, 0, 32'h7);
    tick();
    drive(1, 1, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0);
    @(negedge CLK);
    chk("rq_ren", dc.dmemREN, 1); chk("rq_stall", mem_stall, 1);
    tick();
    #1 chk("rq2_ren", dc.dmemREN, 1);
    #1 nRST = 1'b0;
    #1;
    chk("mid_rst_ren", dc.dmemREN, 0); chk("mid_rst_wen", dc.dmemWEN, 0);
    chk("mid_rst_stall", mem_stall, 0); chk("mid_rst_halt", halt_out, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    #1 nRST = 1'b1;
    tick();
    drive(1, 0, 1, 0, 1, 0, 1, 1, 32'h100, 32'hDD, 0);
    @(negedge CLK);
    chk("post_rst_sc_wen", dc.dmemWEN, !LLSC); chk("post_rst_sc_dload", mem_dload, {31'b0, !LLSC});
    tick();
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    @(negedge CLK);
    chk("halt_out", halt_out, 1); chk("halt_en", memwb_enable, 1);
    tick();
    drive(1, 1, 0, 0, 0, 0, 1, 1, 32'h300, 0, 32'h33);
    @(negedge CLK);
    chk("halted_ren", dc.dmemREN, 0); chk("halted_out", halt_out, 1);
    chk("halted_en", memwb_enable, 1); chk("halted_stall", mem_stall, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
